coherence_snoop_bus: RTL
========================

# coherence_snoop_bus

Parametrised successor to the fixed-width shared cache bus between the per-core L1 controllers and the shared L2. It supports NUM_CORES cores and round-robin arbitration. Snoop responses are collected per core with a timeout, and a dirty line held by another L1 is forwarded cache-to-cache with a writeback to L2. Responses are routed per core instead of broadcast. It sits between the L1 array and L2 inside the top-level cache system.

## Interface
- NUM_CORES, 4, number of L1 ports (2..16)
- LINE_ADDR_BITS, 26, line address width (address minus offset bits)
- LINE_BITS, 512, cacheline width
- SNOOP_TIMEOUT, 15, maximum SNOOP cycles before forced completion (1..255)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- l1_req_valid  in  NUM_CORES  per-core request pending; held until ready
- l1_req_op  in  NUM_CORES×2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 BusWB
- l1_req_addr  in  NUM_CORES×LINE_ADDR_BITS  request line address
- l1_req_data  in  NUM_CORES×LINE_BITS  writeback data (BusWB only)
- l1_req_ready  out  NUM_CORES  one-hot grant/accept pulse
- l1_resp_valid  out  NUM_CORES  one-hot, one-cycle completion to the granted core
- l1_resp_data  out  LINE_BITS  line data, valid with l1_resp_valid (BusRd/BusRdX)
- l1_resp_shared  out  1  another core retains a copy; valid with l1_resp_valid
- l1_snoop_valid  out  NUM_CORES  snoop strobe to every core except the requester
- l1_snoop_addr  out  LINE_ADDR_BITS  latched transaction address
- l1_snoop_op  out  2  latched transaction op
- l1_snoop_done  in  NUM_CORES  snooper finished; qualifies shared/dirty/data
- l1_snoop_shared  in  NUM_CORES  snooper keeps a copy
- l1_snoop_dirty  in  NUM_CORES  snooper holds the line Modified and supplies data
- l1_snoop_data  in  NUM_CORES×LINE_BITS  snooper line data
- l2_req_valid  out  1  L2 request
- l2_req_rw  out  1  0 read, 1 write
- l2_req_addr  out  LINE_ADDR_BITS  L2 address
- l2_req_data  out  LINE_BITS  L2 write data
- l2_req_ready  in  1  L2 accepts the request
- l2_resp_valid  in  1  L2 read data valid (reads only)
- l2_resp_data  in  LINE_BITS  L2 read data
- snoop_timeout_err  out  1  sticky; set on any snoop timeout, cleared only by reset
- busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, SNOOP, L2_WR, L2_RD_REQ, L2_RD_WAIT, RESP. One transaction in flight at a time.
- IDLE:
  - If any l1_req_valid is set, grant g is the first requesting core at or after rr_ptr, scanning with wrap.
  - l1_req_ready[g] is driven combinationally in this cycle. Op, addr and data are latched at the edge.
  - rr_ptr is set to (g+1) mod NUM_CORES at the edge.
  - Next state: BusWB → L2_WR, with the latched data as the write data. All other ops → SNOOP.
- SNOOP:
  - l1_snoop_valid is set for every core except g and held until that core's done is collected.
  - done_mask collects l1_snoop_done per core. The mask bit for g is preset.
  - shared_acc is the OR of the shared bits collected. dirty_acc is the OR of the dirty bits collected.
  - Data is captured from the lowest-index core that reports dirty with done.
  - Completion is either done_mask all ones, or the timeout counter reaching SNOOP_TIMEOUT.
  - On timeout, snoop_timeout_err is set and uncollected cores count as not shared and not dirty.
  - On completion: BusUpgr → RESP. Dirty → L2_WR, with the captured data as the write data. Otherwise → L2_RD_REQ.
- L2_WR:
  - l2_req_valid=1 and rw=1 are held until l2_req_ready, then the FSM goes to RESP.
  - No l2_resp_valid is expected for writes.
  - The response carries the captured dirty data for BusRd/BusRdX. A BusWB response is an acknowledgement only.
- L2_RD_REQ: l2_req_valid=1 and rw=0 are held until l2_req_ready, then the FSM goes to L2_RD_WAIT.
- L2_RD_WAIT: on l2_resp_valid, l2_resp_data is captured and the FSM goes to RESP.
- RESP:
  - l1_resp_valid[g] is set for one cycle. l1_resp_shared = shared_acc, and is forced to 0 for BusRdX and BusWB.
  - The FSM then returns to IDLE. New arbitration happens no earlier than the next cycle.
- Inputs are ignored outside their qualifying states: snoop inputs outside SNOOP, and l2_resp_valid outside L2_RD_WAIT.

## Timing
- Reset: every output is 0, the FSM is IDLE, rr_ptr=0, and done_mask, the accumulators and the timeout counter are cleared.
- Reset mid-transaction aborts the transaction with no response. Requesters must reissue.
- The l1_req_ready pulse is the grant cycle, cycle 0.
- Minimum latencies, with snoop_done and l2_req_ready in the first cycle they are looked at:
  - BusUpgr: l1_resp_valid at cycle 2.
  - BusRd with dirty snooper: l1_resp_valid at cycle 3.
  - BusWB: l1_resp_valid at cycle 2.
  - BusRd served by L2 with l2_resp_valid one cycle after accept: l1_resp_valid at cycle 4.
- The timeout counter starts at 0 on SNOOP entry. Forced completion happens in the cycle the counter equals SNOOP_TIMEOUT, so SNOOP lasts at most SNOOP_TIMEOUT+1 cycles.
- Simultaneous events:
  - l1_snoop_done arriving in the timeout cycle is collected.
  - Of several dirty snoopers, only the lowest index supplies data. This is legal only under a protocol error.
- l2_req_addr, l2_req_data and l2_req_rw are stable while l2_req_valid=1.
- Output l1_resp_data is stable only in the RESP cycle.

## Test plan
- Cores 0–3 all assert BusRd at reset release, with L2 data 0xA5 patterns → grants and responses in order 0,1,2,3, one transaction at a time; l1_resp_shared=0.
- Core 1 BusRd to 0x100, core 2 snoop returns done, dirty and data 0xDEAD → L2 write to 0x100 with data 0xDEAD; core 1 receives 0xDEAD; l2_req_rw=0 never issued.
- Core 0 BusUpgr, cores 1–3 done on cycle 1 with core 3 shared → l1_resp_valid[0] at cycle 2 and no L2 request.
- Core 2 BusRd, core 3 never asserts done, SNOOP_TIMEOUT=15 → SNOOP lasts 16 cycles, snoop_timeout_err=1 and stays 1 afterwards, and the request is served from L2.
- Core 3 BusWB to 0x3FF with L2 ready held low for 5 cycles → l2_req_valid held for 6 cycles with address and data stable, then l1_resp_valid[3].
- Reset asserted in L2_RD_WAIT → next cycle all outputs are 0 and the FSM is IDLE; after release, core 0 wins first.

Source files
------------

// File: rtl/coherence_snoop_bus.sv
// Snooping coherence bus between NUM_CORES L1 controllers and a shared L2.
// Round-robin grant, per-core snoop collection with timeout, dirty forwarding with L2 writeback.
module coherence_snoop_bus #(
  parameter int NUM_CORES      = 4,
  parameter int LINE_ADDR_BITS = 26,
  parameter int LINE_BITS      = 512,
  parameter int SNOOP_TIMEOUT  = 15
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CORES-1:0]                l1_req_valid,
  input  logic [2*NUM_CORES-1:0]              l1_req_op,
  input  logic [NUM_CORES*LINE_ADDR_BITS-1:0] l1_req_addr,
  input  logic [NUM_CORES*LINE_BITS-1:0]      l1_req_data,
  output logic [NUM_CORES-1:0]                l1_req_ready,
  output logic [NUM_CORES-1:0]                l1_resp_valid,
  output logic [LINE_BITS-1:0]                l1_resp_data,
  output logic                                l1_resp_shared,
  output logic [NUM_CORES-1:0]                l1_snoop_valid,
  output logic [LINE_ADDR_BITS-1:0]           l1_snoop_addr,
  output logic [1:0]                          l1_snoop_op,
  input  logic [NUM_CORES-1:0]                l1_snoop_done,
  input  logic [NUM_CORES-1:0]                l1_snoop_shared,
  input  logic [NUM_CORES-1:0]                l1_snoop_dirty,
  input  logic [NUM_CORES*LINE_BITS-1:0]      l1_snoop_data,
  output logic                                l2_req_valid,
  output logic                                l2_req_rw,
  output logic [LINE_ADDR_BITS-1:0]           l2_req_addr,
  output logic [LINE_BITS-1:0]                l2_req_data,
  input  logic                                l2_req_ready,
  input  logic                                l2_resp_valid,
  input  logic [LINE_BITS-1:0]                l2_resp_data,
  output logic                                snoop_timeout_err,
  output logic                                busy
);

  localparam int               IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int               CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] NC_W  = CNT_W'(NUM_CORES);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_CORES - 1);
  localparam logic [7:0]       TMO   = 8'(SNOOP_TIMEOUT);

  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_RDX  = 2'b01;
  localparam logic [1:0] OP_UPGR = 2'b10;
  localparam logic [1:0] OP_WB   = 2'b11;

  typedef enum logic [2:0] {IDLE, SNOOP, L2_WR, L2_RD_REQ, L2_RD_WAIT, RESP} state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          rr_ptr, gnt, arb_idx, cap_idx, dirty_idx;
  logic [CNT_W-1:0]          scan;
  logic                      arb_found, grant_en;
  logic [1:0]                op_q;
  logic [LINE_ADDR_BITS-1:0] addr_q;
  logic [LINE_BITS-1:0]      data_q;
  logic [NUM_CORES-1:0]      done_mask, new_done, new_dirty, gnt_oh;
  logic                      shared_acc, dirty_acc, shared_nxt, dirty_nxt, dirty_hit;
  logic                      done_all, snoop_tmo, snoop_complete, capture;
  logic [7:0]                tmo_cnt;
  logic                      err_q;

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_CORES
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      scan = {1'b0, rr_ptr} + CNT_W'(i);
      if (scan >= NC_W) scan = scan - NC_W;
      if (!arb_found && l1_req_valid[scan[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = scan[IDX_W-1:0];
      end
    end
  end

  assign grant_en = arb_found && !reset;
  assign gnt_oh   = NUM_CORES'(1) << arb_idx;

  // Snoop collection: only cores not yet collected contribute this cycle
  assign new_done       = l1_snoop_done & ~done_mask;
  assign new_dirty      = new_done & l1_snoop_dirty;
  assign done_all       = &(done_mask | l1_snoop_done);
  assign snoop_tmo      = (tmo_cnt == TMO);
  assign snoop_complete = done_all || snoop_tmo;
  assign shared_nxt     = shared_acc || (|(new_done & l1_snoop_shared));
  assign dirty_nxt      = dirty_acc || dirty_hit;
  assign capture        = dirty_hit && (!dirty_acc || (dirty_idx < cap_idx));

  always_comb begin
    dirty_hit = 1'b0;
    dirty_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (new_dirty[i]) begin
        dirty_hit = 1'b1;
        dirty_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    l1_req_ready   = '0;
    l1_resp_valid  = '0;
    l1_resp_data   = '0;
    l1_resp_shared = 1'b0;
    l1_snoop_valid = '0;
    l1_snoop_addr  = '0;
    l1_snoop_op    = '0;
    l2_req_valid   = 1'b0;
    l2_req_rw      = 1'b0;
    l2_req_addr    = '0;
    l2_req_data    = '0;
    case (state)
      IDLE: begin
        if (grant_en) begin
          l1_req_ready[arb_idx] = 1'b1;
          state_nxt = (l1_req_op[arb_idx*2 +: 2] == OP_WB) ? L2_WR : SNOOP;
        end
      end
      SNOOP: begin
        l1_snoop_valid = ~done_mask;
        l1_snoop_addr  = addr_q;
        l1_snoop_op    = op_q;
        if (snoop_complete) begin
          if (op_q == OP_UPGR)  state_nxt = RESP;
          else if (dirty_nxt)   state_nxt = L2_WR;
          else                  state_nxt = L2_RD_REQ;
        end
      end
      L2_WR: begin
        l2_req_valid = 1'b1;
        l2_req_rw    = 1'b1;
        l2_req_addr  = addr_q;
        l2_req_data  = data_q;
        if (l2_req_ready) state_nxt = RESP;
      end
      L2_RD_REQ: begin
        l2_req_valid = 1'b1;
        l2_req_addr  = addr_q;
        if (l2_req_ready) state_nxt = L2_RD_WAIT;
      end
      L2_RD_WAIT: begin
        if (l2_resp_valid) state_nxt = RESP;
      end
      RESP: begin
        l1_resp_valid[gnt] = 1'b1;
        if (op_q == OP_RD || op_q == OP_RDX) l1_resp_data = data_q;
        l1_resp_shared = shared_acc && (op_q == OP_RD || op_q == OP_UPGR);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy              = (state != IDLE);
  assign snoop_timeout_err = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gnt        <= '0;
      done_mask  <= '0;
      shared_acc <= 1'b0;
      dirty_acc  <= 1'b0;
      cap_idx    <= '0;
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (arb_found) begin
            gnt        <= arb_idx;
            rr_ptr     <= (arb_idx == LAST) ? '0 : arb_idx + 1'b1;
            done_mask  <= gnt_oh;
            shared_acc <= 1'b0;
            dirty_acc  <= 1'b0;
            tmo_cnt    <= '0;
          end
        end
        SNOOP: begin
          done_mask  <= done_mask | l1_snoop_done;
          shared_acc <= shared_nxt;
          dirty_acc  <= dirty_nxt;
          if (capture) cap_idx <= dirty_idx;
          if (!snoop_complete) tmo_cnt <= tmo_cnt + 8'd1;
          // Uncollected cores at timeout are treated as clean and unshared
          if (snoop_tmo && !done_all) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Transaction payload; outputs are gated by state so these need no reset
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (arb_found) begin
          op_q   <= l1_req_op[arb_idx*2 +: 2];
          addr_q <= l1_req_addr[arb_idx*LINE_ADDR_BITS +: LINE_ADDR_BITS];
          data_q <= l1_req_data[arb_idx*LINE_BITS +: LINE_BITS];
        end
      end
      SNOOP:      if (capture) data_q <= l1_snoop_data[dirty_idx*LINE_BITS +: LINE_BITS];
      L2_RD_WAIT: if (l2_resp_valid) data_q <= l2_resp_data;
      default: ;
    endcase
  end

endmodule
